// File: rtl/mix_optim_sched.sv
// Optimizer pass sequencer: steps through the enabled units one at a time,
// with a settle cycle before each run and a drain cycle after it.
module mix_optim_sched #(
    parameter int unsigned N_UNIT  = 4,
    parameter int unsigned UNIT_W  = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned STEP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_UNIT-1:0] enable_mask,
    input  logic [N_UNIT-1:0] unit_valid,
    input  logic              clear_err,
    output logic [N_UNIT-1:0] run,
    output logic [UNIT_W-1:0] sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] step_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [N_UNIT-1:0]   pending, pending_next;
    logic [TMR_W-1:0]    timer, timer_next;
    logic [UNIT_W-1:0]   sel_next;
    logic [N_UNIT-1:0]   run_next;
    logic                busy_next, done_next, err_next;
    logic [STEP_W-1:0]   step_next;
    logic [N_UNIT-1:0]   sel_oh, remaining;
    logic                valid_sel, timer_hit;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [UNIT_W-1:0] lowest_idx(input logic [N_UNIT-1:0] m);
        logic [UNIT_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_UNIT) - 1; i >= 0; i--) begin
            if (m[i]) idx = UNIT_W'(i);
        end
        return idx;
    endfunction

    // One-hot decode of a unit index, limited to the implemented units.
    function automatic logic [N_UNIT-1:0] unit_oh(input logic [UNIT_W-1:0] s);
        logic [N_UNIT-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(N_UNIT); i++) begin
            oh[i] = (UNIT_W'(i) == s);
        end
        return oh;
    endfunction

    // Completion of the selected unit only; other valid bits are don't-care.
    always_comb begin
        sel_oh    = unit_oh(sel);
        valid_sel = |(unit_valid & sel_oh);
        timer_hit = (timer == TMR_W'(TIMEOUT - 1));
        remaining = pending & ~sel_oh;
    end

    // Next-state and next-output logic; outputs are registered from next state.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        timer_next   = timer;
        sel_next     = sel;
        err_next     = err;
        step_next    = step_cnt;

        // Clear first so a same-cycle timeout set takes priority.
        if (clear_err) err_next = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (|enable_mask) begin
                        pending_next = enable_mask;
                        sel_next     = lowest_idx(enable_mask);
                        state_next   = ARM;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ARM: begin
                timer_next = '0;
                state_next = RUN;
            end
            RUN: begin
                if (valid_sel) begin
                    state_next = DRAIN;
                end else if (timer_hit) begin
                    err_next   = 1'b1;
                    state_next = DRAIN;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            DRAIN: begin
                pending_next = remaining;
                if (|remaining) begin
                    sel_next   = lowest_idx(remaining);
                    state_next = ARM;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        run_next  = (state_next == RUN) ? unit_oh(sel_next) : '0;
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
        if (state_next == DONE) step_next = step_cnt + 1'b1;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            timer    <= '0;
            sel      <= '0;
            run      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            timer    <= timer_next;
            sel      <= sel_next;
            run      <= run_next;
            busy     <= busy_next;
            done     <= done_next;
            err      <= err_next;
            step_cnt <= step_next;
        end
    end

endmodule

// File: tb/tb_mix_optim_sched.sv
// Scoreboard bench for mix_optim_sched: expected unit runs and done results
// are queued when a pass is launched and consumed by a negedge monitor.
module tb_mix_optim_sched;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int SW = 4;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] enable_mask;
    logic [N-1:0] unit_valid;
    logic         clear_err;
    logic [N-1:0] run;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic         err;
    logic [SW-1:0] step_cnt;

    mix_optim_sched #(
        .N_UNIT (N),
        .UNIT_W (2),
        .TIMEOUT(TO),
        .STEP_W (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .enable_mask(enable_mask),
        .unit_valid (unit_valid),
        .clear_err  (clear_err),
        .run        (run),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Unit model: valid rises after delay[i] run-high cycles; noise drives idle units.
    int           delay[N];
    int           rcnt[N];
    logic [N-1:0] noise;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || !run[i]) begin
                rcnt[i] = 0;
                unit_valid[i] = rst ? 1'b0 : noise[i];
            end else begin
                rcnt[i] = rcnt[i] + 1;
                unit_valid[i] = (rcnt[i] > delay[i]);
            end
        end
    end

    // Scoreboard queues and reference state.
    int          exp_unit_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_step_q[$];
    logic [31:0] exp_err_q[$];
    int          step_m = 0;
    logic        err_m = 1'b0;

    // Monitor: checks each run burst and each done pulse against the queues.
    logic [N-1:0] prev_run = '0;
    logic         prev_done = 1'b0;
    int           cur_len = 0;
    int           cur_exp_len = 0;
    int           mon_u;

    always @(negedge clk) begin
        if (rst) begin
            prev_run  = '0;
            prev_done = 1'b0;
            cur_len   = 0;
        end else begin
            if (run != 0 && run != prev_run) begin
                check("run_gap", 32'(prev_run), 0);
                check("run_onehot", 32'($onehot(run)), 1);
                if (exp_unit_q.size() == 0) begin
                    check("run_unexpected", 32'(run), 0);
                    cur_exp_len = 0;
                end else begin
                    mon_u       = exp_unit_q.pop_front();
                    cur_exp_len = exp_len_q.pop_front();
                    check("run_unit", 32'(run), 32'(1 << mon_u));
                    check("sel_run", 32'(sel), 32'(mon_u));
                end
                cur_len = 0;
            end
            if (run != 0) cur_len++;
            if (run == 0 && prev_run != 0) check("run_len", 32'(cur_len), 32'(cur_exp_len));
            if (done) begin
                if (exp_step_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("done_step", 32'(step_cnt), exp_step_q.pop_front());
                    check("done_err", 32'(err), exp_err_q.pop_front());
                end
            end
            if (prev_done) check("done_width", 32'(done), 0);
            prev_run  = run;
            prev_done = done;
        end
    end

    // Launch one pass, queue its expectations and measure start-to-done latency.
    task automatic do_pass(input logic [N-1:0] mask, input int d0, input int d1,
                           input int d2, input int d3, input bit poke);
        int d[N];
        int len;
        int lat;
        int n;
        bit seen;
        d = '{d0, d1, d2, d3};
        lat = 1;
        for (int i = 0; i < N; i++) delay[i] = d[i];
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                len = (d[i] + 1 > TO) ? TO : d[i] + 1;
                if (d[i] + 1 > TO) err_m = 1'b1;
                exp_unit_q.push_back(i);
                exp_len_q.push_back(len);
                lat += len + 2;
            end
        end
        step_m = (step_m + 1) % (1 << SW);
        exp_step_q.push_back(32'(step_m));
        exp_err_q.push_back(32'(err_m));

        @(negedge clk);
        start = 1'b1;
        enable_mask = mask;
        @(posedge clk);
        #1;
        start = 1'b0;
        enable_mask = 4'($urandom);
        n = 0;
        seen = 1'b0;
        while (n < 600 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_pass", 32'(busy), 1);
            if (poke && n == 4) begin
                start = 1'b1;
                enable_mask = 4'b1111;
            end
            if (poke && n == 5) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("latency", 32'(n), 32'(lat));
        @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    int wn;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        enable_mask = '0;
        clear_err = 1'b0;
        noise = '0;
        for (int i = 0; i < N; i++) delay[i] = 0;
        idle(3);
        check("rst_run", 32'(run), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_step", 32'(step_cnt), 0);
        rst = 1'b0;
        idle(2);

        // All four units in order, 10 idle run cycles each.
        do_pass(4'b1111, 10, 10, 10, 10, 1'b0);
        check("err_after_full", 32'(err), 0);

        // Sparse mask with noise on unselected valid lines; sel holds in IDLE.
        noise = 4'b0101;
        do_pass(4'b1010, 0, 10, 0, 5, 1'b0);
        noise = '0;
        idle(3);
        check("sel_hold", 32'(sel), 3);
        check("busy_idle", 32'(busy), 0);

        // Unit 0 never completes: timeout after 16 run cycles, then clear.
        do_pass(4'b0001, NEVER, 0, 0, 0, 1'b0);
        check("err_set", 32'(err), 1);
        idle(2);
        check("err_sticky", 32'(err), 1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        err_m = 1'b0;
        check("err_clear", 32'(err), 0);

        // Empty mask: done on the first cycle, no run activity.
        do_pass(4'b0000, 0, 0, 0, 0, 1'b0);

        // Start pulsed mid-pass must not queue a second pass.
        do_pass(4'b1111, 3, 3, 3, 3, 1'b1);
        idle(4);
        check("poke_idle", 32'(busy), 0);
        check("poke_step", 32'(step_cnt), 32'(step_m));

        // Reset while unit 2 runs.
        for (int i = 0; i < N; i++) delay[i] = 10;
        exp_unit_q.push_back(0); exp_len_q.push_back(11);
        exp_unit_q.push_back(1); exp_len_q.push_back(11);
        exp_unit_q.push_back(2); exp_len_q.push_back(11);
        @(negedge clk);
        start = 1'b1;
        enable_mask = 4'b1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        wn = 0;
        while (wn < 200 && run[2] !== 1'b1) begin
            @(negedge clk);
            wn++;
        end
        check("wait_run2", 32'(run[2]), 1);
        rst = 1'b1;
        #1;
        check("midrst_run", 32'(run), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_step", 32'(step_cnt), 0);
        check("midrst_done", 32'(done), 0);
        exp_unit_q.delete();
        exp_len_q.delete();
        exp_step_q.delete();
        exp_err_q.delete();
        step_m = 0;
        err_m = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        do_pass(4'b1111, 2, 2, 2, 2, 1'b0);

        // Wrap step_cnt: 14 empty passes then a valid-on-timeout pass (16th).
        for (int k = 0; k < 14; k++) do_pass(4'b0000, 0, 0, 0, 0, 1'b0);
        check("step_15", 32'(step_cnt), 15);
        do_pass(4'b0001, TO - 1, 0, 0, 0, 1'b0);
        check("step_wrap", 32'(step_cnt), 0);
        check("coincident_err", 32'(err), 0);

        idle(3);
        check("q_units_empty", 32'(exp_unit_q.size()), 0);
        check("q_done_empty", 32'(exp_step_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
